seq_divider: RTL

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 113 +++++++++++
 1 files changed

// File: rtl/seq_divider.sv
//==============================================================================
// Module      : seq_divider
// Description : 16/8 unsigned restoring divider, one quotient bit per cycle.
//               Optional macro SEQ_DIVIDER_DBZ_EN enables a divide-by-zero fast path.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module seq_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        busy,
    output logic        done,
    output logic        dbz
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_dvd;
    logic [7:0]  r_dvs;
    logic [3:0]  r_cnt;
    logic        w_accept;
    logic        w_last;
    logic        w_fast;
    logic [8:0]  w_partial;
    logic        w_ge;
    logic [7:0]  w_diff;

`ifdef SEQ_DIVIDER_DBZ_EN
    logic r_dbz;
    assign w_fast = r_dbz;
    assign dbz    = r_dbz;
`else
    assign w_fast = 1'b0;
    assign dbz    = 1'b0;
`endif

    assign w_accept  = start && (r_state != S_RUN);
    assign w_last    = (r_cnt == 4'd15);
    assign w_partial = {remainder, r_dvd[15]};
    assign w_ge      = (w_partial >= {1'b0, r_dvs});
    // When the subtract is taken the difference always fits in 8 bits.
    assign w_diff    = w_partial[7:0] - r_dvs;

    assign busy = (r_state == S_RUN) && !w_fast;
    assign done = (r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_last || w_fast) w_next = S_DONE;
            S_DONE:  w_next = start ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dvd     <= 16'd0;
            r_dvs     <= 8'd0;
            r_cnt     <= 4'd0;
            quotient  <= 16'd0;
            remainder <= 8'd0;
`ifdef SEQ_DIVIDER_DBZ_EN
            r_dbz     <= 1'b0;
`endif
        end else if (w_accept) begin
            r_dvd     <= dividend;
            r_dvs     <= divisor;
            r_cnt     <= 4'd0;
            quotient  <= 16'd0;
            remainder <= 8'd0;
`ifdef SEQ_DIVIDER_DBZ_EN
            r_dbz     <= (divisor == 8'd0);
`endif
        end else if (r_state == S_RUN) begin
            r_dvd     <= {r_dvd[14:0], 1'b0};
            quotient  <= {quotient[14:0], w_ge};
            remainder <= w_ge ? w_diff : w_partial[7:0];
            r_cnt     <= r_cnt + 4'd1;
`ifdef SEQ_DIVIDER_DBZ_EN
            // Zero divisor skips the iteration and loads the saturated result.
            if (r_dbz) begin
                quotient  <= 16'hFFFF;
                remainder <= r_dvd[7:0];
            end
`endif
        end
    end

endmodule

`default_nettype wire
